trig_arbiter: RTL and testbench

Sequencer and arbiter that shares one combinational sine lookup table between two requesters. For each granted request it issues two lookups: sine at theta, then cosine as the sine at theta plus a quarter turn. It returns the registered (sin, cos) pair with a one-cycle valid pulse. It sits between the game logic (ball launch, paddle-deflection angle) and a single `sin` LUT instance, so the design needs only one trig table.

---
 rtl/trig_arbiter_if.sv | 23 ++
 rtl/trig_arbiter.sv | 121 ++++++++++++
 tb/tb_trig_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_arbiter_if.sv
// Requester-side bundle for trig_arbiter.
// master = game logic issuing requests, slave = the arbiter.
interface trig_arbiter_if #(
    parameter int THETA_WIDTH = 6
);
    logic [1:0]             req_i;
    logic [THETA_WIDTH-1:0] theta0_i;
    logic [THETA_WIDTH-1:0] theta1_i;
    logic [1:0]             gnt_o;
    logic [7:0]             sin_o;
    logic [7:0]             cos_o;
    logic [1:0]             valid_o;

    modport master (
        output req_i, theta0_i, theta1_i,
        input  gnt_o, sin_o, cos_o, valid_o
    );

    modport slave (
        input  req_i, theta0_i, theta1_i,
        output gnt_o, sin_o, cos_o, valid_o
    );
endinterface

// File: rtl/trig_arbiter.sv
// trig_arbiter: shares one combinational sine LUT between two requesters.
// Each granted request does two lookups: sin(theta), then sin(theta + quarter
// turn) as the cosine. The (sin, cos) pair is returned with a one-cycle valid.
// Optional feature macro: TRIG_ARB_ROUND_ROBIN_EN (round-robin tie breaking);
// when undefined, requester 0 has fixed priority on ties.
//
// state | meaning
// IDLE  | sample req_i, pick winner, latch its angle
// SIN   | gnt pulse, LUT addressed with theta, capture sine
// COS   | LUT addressed with theta + quarter turn, capture cosine
// DONE  | valid pulse to owner, update last-winner
module trig_arbiter #(
    parameter int THETA_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    trig_arbiter_if.slave          bus,
    output logic [THETA_WIDTH-1:0] lut_theta_o,
    input  logic [7:0]             lut_sin_i
);

    if (THETA_WIDTH < 3) begin : g_bad_width
        $error("trig_arbiter: THETA_WIDTH must be >= 3");
    end

    localparam logic [THETA_WIDTH-1:0] QUARTER = THETA_WIDTH'(1) << (THETA_WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIN  = 2'd1,
        COS  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [THETA_WIDTH-1:0] r_theta_l;
    logic                   r_owner;
    logic                   w_winner;
    logic [THETA_WIDTH-1:0] w_theta_sel;

`ifdef TRIG_ARB_ROUND_ROBIN_EN
    logic r_last_winner;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req_i == 2'b10) begin
            w_winner = 1'b1;
        end else if (bus.req_i == 2'b11) begin
            w_winner = ~r_last_winner;
        end
    end

    // Last-winner history, updated once the transaction completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_winner <= 1'b1;
        end else if (r_state == DONE) begin
            r_last_winner <= r_owner;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req_i == 2'b10) begin
            w_winner = 1'b1;
        end
    end
`endif

    // Angle of the winning requester.
    always_comb begin
        w_theta_sel = w_winner ? bus.theta1_i : bus.theta0_i;
    end

    // Sequencer FSM; every output is a register so nothing passes req/theta
    // combinationally to the outputs. The LUT address is loaded one state
    // early so it is already stable in the cycle its data is captured.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_theta_l    <= '0;
            r_owner      <= 1'b0;
            lut_theta_o  <= '0;
            bus.gnt_o    <= 2'b00;
            bus.valid_o  <= 2'b00;
            bus.sin_o    <= 8'h00;
            bus.cos_o    <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_i != 2'b00) begin
                        r_theta_l   <= w_theta_sel;
                        r_owner     <= w_winner;
                        lut_theta_o <= w_theta_sel;
                        bus.gnt_o   <= w_winner ? 2'b10 : 2'b01;
                        r_state     <= SIN;
                    end
                end
                SIN: begin
                    bus.gnt_o   <= 2'b00;
                    bus.sin_o   <= lut_sin_i;
                    lut_theta_o <= r_theta_l + QUARTER;
                    r_state     <= COS;
                end
                COS: begin
                    bus.cos_o   <= lut_sin_i;
                    bus.valid_o <= r_owner ? 2'b10 : 2'b01;
                    r_state     <= DONE;
                end
                DONE: begin
                    bus.valid_o <= 2'b00;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_arbiter.sv
// Directed bench for trig_arbiter with an identity LUT (lut[k] = k).
module tb_trig_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [5:0] lut_theta;
    logic [7:0] lut_sin;
    int         checks;
    int         failures;

    trig_arbiter_if #(.THETA_WIDTH(6)) bus ();

    trig_arbiter #(.THETA_WIDTH(6)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus),
        .lut_theta_o (lut_theta),
        .lut_sin_i   (lut_sin)
    );

    assign lut_sin = {2'b00, lut_theta};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N        = 1'b0;
        bus.req_i    = 2'b00;
        bus.theta0_i = 6'd0;
        bus.theta1_i = 6'd0;
        repeat (3) step();
        checks++;
        if (bus.gnt_o !== 2'b00 || bus.valid_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_gnt_valid got gnt=%b valid=%b exp 00/00", bus.gnt_o, bus.valid_o);
        end
        checks++;
        if (bus.sin_o !== 8'd0 || bus.cos_o !== 8'd0 || lut_theta !== 6'd0) begin
            failures++;
            $display("FAIL reset_data got sin=%0d cos=%0d lut=%0d exp 0/0/0", bus.sin_o, bus.cos_o, lut_theta);
        end
        RST_N = 1'b1;
        step();
        checks++;
        if (bus.gnt_o !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle_gnt got %b exp 00", bus.gnt_o);
        end
    endtask

    task automatic test_single();
        bus.req_i    = 2'b01;
        bus.theta0_i = 6'd5;
        step();
        checks++;
        if (bus.gnt_o !== 2'b01 || lut_theta !== 6'd5) begin
            failures++;
            $display("FAIL single_gnt got gnt=%b lut=%0d exp 01/5", bus.gnt_o, lut_theta);
        end
        bus.req_i = 2'b00;
        step();
        checks++;
        if (bus.gnt_o !== 2'b00 || lut_theta !== 6'd21 || bus.valid_o !== 2'b00) begin
            failures++;
            $display("FAIL single_cos got gnt=%b lut=%0d valid=%b exp 00/21/00", bus.gnt_o, lut_theta, bus.valid_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 2'b01 || bus.sin_o !== 8'd5 || bus.cos_o !== 8'd21) begin
            failures++;
            $display("FAIL single_result got valid=%b sin=%0d cos=%0d exp 01/5/21", bus.valid_o, bus.sin_o, bus.cos_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 2'b00) begin
            failures++;
            $display("FAIL single_valid_pulse got %b exp 00", bus.valid_o);
        end
    endtask

    task automatic test_wrap();
        bus.req_i    = 2'b10;
        bus.theta1_i = 6'd60;
        step();
        checks++;
        if (bus.gnt_o !== 2'b10 || lut_theta !== 6'd60) begin
            failures++;
            $display("FAIL wrap_gnt got gnt=%b lut=%0d exp 10/60", bus.gnt_o, lut_theta);
        end
        bus.req_i = 2'b00;
        step();
        checks++;
        if (lut_theta !== 6'd12) begin
            failures++;
            $display("FAIL wrap_addr got %0d exp 12", lut_theta);
        end
        step();
        checks++;
        if (bus.valid_o !== 2'b10 || bus.sin_o !== 8'd60 || bus.cos_o !== 8'd12) begin
            failures++;
            $display("FAIL wrap_result got valid=%b sin=%0d cos=%0d exp 10/60/12", bus.valid_o, bus.sin_o, bus.cos_o);
        end
        step();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        logic [7:0] exp_s;
        logic [7:0] exp_c;
`ifdef TRIG_ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        bus.req_i    = 2'b11;
        bus.theta0_i = 6'd3;
        bus.theta1_i = 6'd7;
        for (int k = 0; k < 4; k++) begin
            exp_s = (exp_g[k] == 2'b01) ? 8'd3 : 8'd7;
            exp_c = (exp_g[k] == 2'b01) ? 8'd19 : 8'd23;
            step();
            checks++;
            if (bus.gnt_o !== exp_g[k]) begin
                failures++;
                $display("FAIL contend_gnt[%0d] got %b exp %b", k, bus.gnt_o, exp_g[k]);
            end
            step();
            step();
            checks++;
            if (bus.valid_o !== exp_g[k] || bus.sin_o !== exp_s || bus.cos_o !== exp_c) begin
                failures++;
                $display("FAIL contend_result[%0d] got valid=%b sin=%0d cos=%0d exp %b/%0d/%0d",
                         k, bus.valid_o, bus.sin_o, bus.cos_o, exp_g[k], exp_s, exp_c);
            end
            step();
            checks++;
            if (bus.gnt_o !== 2'b00 || bus.valid_o !== 2'b00) begin
                failures++;
                $display("FAIL contend_idle[%0d] got gnt=%b valid=%b exp 00/00", k, bus.gnt_o, bus.valid_o);
            end
        end
        bus.req_i = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        bus.req_i    = 2'b01;
        bus.theta0_i = 6'd9;
        step();
        checks++;
        if (bus.gnt_o !== 2'b01) begin
            failures++;
            $display("FAIL busy_gnt0 got %b exp 01", bus.gnt_o);
        end
        bus.req_i    = 2'b10;
        bus.theta1_i = 6'd30;
        step();
        checks++;
        if (bus.gnt_o !== 2'b00) begin
            failures++;
            $display("FAIL busy_no_early_gnt got %b exp 00", bus.gnt_o);
        end
        step();
        checks++;
        if (bus.valid_o !== 2'b01 || bus.sin_o !== 8'd9 || bus.cos_o !== 8'd25) begin
            failures++;
            $display("FAIL busy_result0 got valid=%b sin=%0d cos=%0d exp 01/9/25", bus.valid_o, bus.sin_o, bus.cos_o);
        end
        step();
        step();
        checks++;
        if (bus.gnt_o !== 2'b10 || lut_theta !== 6'd30) begin
            failures++;
            $display("FAIL busy_gnt1 got gnt=%b lut=%0d exp 10/30", bus.gnt_o, lut_theta);
        end
        bus.req_i = 2'b00;
        step();
        step();
        checks++;
        if (bus.valid_o !== 2'b10 || bus.sin_o !== 8'd30 || bus.cos_o !== 8'd46) begin
            failures++;
            $display("FAIL busy_result1 got valid=%b sin=%0d cos=%0d exp 10/30/46", bus.valid_o, bus.sin_o, bus.cos_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.req_i    = 2'b01;
        bus.theta0_i = 6'd11;
        step();
        step();
        checks++;
        if (lut_theta !== 6'd27) begin
            failures++;
            $display("FAIL rstmid_cos_addr got %0d exp 27", lut_theta);
        end
        #1 RST_N = 1'b0;
        #1;
        checks++;
        if (bus.gnt_o !== 2'b00 || bus.valid_o !== 2'b00 || bus.sin_o !== 8'd0 ||
            bus.cos_o !== 8'd0 || lut_theta !== 6'd0) begin
            failures++;
            $display("FAIL rstmid_async got gnt=%b valid=%b sin=%0d cos=%0d lut=%0d exp all 0",
                     bus.gnt_o, bus.valid_o, bus.sin_o, bus.cos_o, lut_theta);
        end
        step();
        checks++;
        if (bus.valid_o !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_no_valid got %b exp 00", bus.valid_o);
        end
        RST_N = 1'b1;
        step();
        checks++;
        if (bus.gnt_o !== 2'b01 || lut_theta !== 6'd11) begin
            failures++;
            $display("FAIL rstmid_regrant got gnt=%b lut=%0d exp 01/11", bus.gnt_o, lut_theta);
        end
        bus.req_i = 2'b00;
        step();
        step();
        checks++;
        if (bus.valid_o !== 2'b01 || bus.sin_o !== 8'd11 || bus.cos_o !== 8'd27) begin
            failures++;
            $display("FAIL rstmid_result got valid=%b sin=%0d cos=%0d exp 01/11/27", bus.valid_o, bus.sin_o, bus.cos_o);
        end
        step();
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.gnt_o !== 2'b00 || bus.valid_o !== 2'b00 ||
                bus.sin_o !== 8'd11 || bus.cos_o !== 8'd27) begin
                failures++;
                $display("FAIL idle_hold[%0d] got gnt=%b valid=%b sin=%0d cos=%0d exp 00/00/11/27",
                         i, bus.gnt_o, bus.valid_o, bus.sin_o, bus.cos_o);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_idle_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
